// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking access controller.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CODE,
        OPEN,
        BLOCKED,
        ALARM
    } park_state_e;

    localparam logic [15:0] DEF_PIN       = 16'h1234;
    localparam int          DEF_MAX_TRIES = 3;
    localparam int          DEF_TIMEOUT   = 64;
    localparam int          DEF_CAPACITY  = 8;
    localparam int          TRIES_W       = 4;

endpackage

// File: rtl/parking_occ_counter.sv
// Saturating up/down vehicle counter; simultaneous up and down cancel out.
module parking_occ_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int OCC_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [OCC_W-1:0] count,
    output logic             full
);

    localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

    logic [OCC_W-1:0] count_q;
    logic [OCC_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && count_q != CAP) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == CAP);

endmodule

// File: rtl/parking_controller_param.sv
// Parking entry gate: PIN check with lockout, code timeout, tailgate alarm
// and occupancy tracking. All control outputs are registered.
module parking_controller_param
    import parking_pkg::*;
#(
    parameter int                CODE_W    = 16,
    parameter logic [CODE_W-1:0] PIN       = CODE_W'(DEF_PIN),
    parameter int                MAX_TRIES = DEF_MAX_TRIES,
    parameter int                TIMEOUT   = DEF_TIMEOUT,
    parameter int                CAPACITY  = DEF_CAPACITY,
    localparam int               OCC_W     = $clog2(CAPACITY + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vehicle_arrival,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    input  logic              vehicle_left,
    input  logic              vehicle_exit,
    output logic              open_gate,
    output logic              close_gate,
    output logic              wrong_pin,
    output logic              blocked_gate,
    output logic              gate_alarm,
    output logic              lot_full,
    output logic [OCC_W-1:0]  occupancy
);

    localparam int                 TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TRIES_W-1:0] TRY_MAX  = TRIES_W'(MAX_TRIES);

    park_state_e        state_q, state_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               open_q, open_d;
    logic               close_q, close_d;
    logic               wrong_q, wrong_d;
    logic               block_q, block_d;
    logic               alarm_q, alarm_d;
    logic               occ_inc;
    logic               pin_ok;

    assign pin_ok = code_valid && (code == PIN);

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        timer_d = timer_q;
        close_d = 1'b0;
        wrong_d = 1'b0;
        occ_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vehicle_arrival && !lot_full) begin
                    state_d = WAIT_CODE;
                    timer_d = '0;
                end
            end
            WAIT_CODE: begin
                if (code_valid) begin
                    timer_d = '0;
                    if (code == PIN) begin
                        state_d = OPEN;
                        tries_d = '0;
                    end else begin
                        wrong_d = 1'b1;
                        tries_d = tries_q + 1'b1;
                        if (tries_d >= TRY_MAX) begin
                            state_d = BLOCKED;
                        end
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = IDLE;
                    tries_d = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            OPEN: begin
                if (vehicle_left) begin
                    occ_inc = 1'b1;
                    if (vehicle_arrival) begin
                        state_d = ALARM;
                    end else begin
                        state_d = IDLE;
                        close_d = 1'b1;
                    end
                end
            end
            BLOCKED, ALARM: begin
                if (pin_ok) begin
                    state_d = IDLE;
                    tries_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Level outputs follow the state being entered, giving one-cycle latency.
        open_d  = (state_d == OPEN);
        block_d = (state_d == BLOCKED) || (state_d == ALARM);
        alarm_d = (state_d == ALARM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tries_q <= '0;
            timer_q <= '0;
            open_q  <= 1'b0;
            close_q <= 1'b0;
            wrong_q <= 1'b0;
            block_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
            open_q  <= open_d;
            close_q <= close_d;
            wrong_q <= wrong_d;
            block_q <= block_d;
            alarm_q <= alarm_d;
        end
    end

    parking_occ_counter #(
        .CAPACITY (CAPACITY),
        .OCC_W    (OCC_W)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .inc   (occ_inc),
        .dec   (vehicle_exit),
        .count (occupancy),
        .full  (lot_full)
    );

    assign open_gate    = open_q;
    assign close_gate   = close_q;
    assign wrong_pin    = wrong_q;
    assign blocked_gate = block_q;
    assign gate_alarm   = alarm_q;

endmodule

// File: tb/tb_parking_controller_param.sv
// Directed bench for parking_controller_param with default parameters.
module tb_parking_controller_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        vehicle_arrival;
    logic [15:0] code;
    logic        code_valid;
    logic        vehicle_left;
    logic        vehicle_exit;
    logic        open_gate;
    logic        close_gate;
    logic        wrong_pin;
    logic        blocked_gate;
    logic        gate_alarm;
    logic        lot_full;
    logic [3:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    parking_controller_param dut (
        .clk             (clk),
        .rst             (rst),
        .vehicle_arrival (vehicle_arrival),
        .code            (code),
        .code_valid      (code_valid),
        .vehicle_left    (vehicle_left),
        .vehicle_exit    (vehicle_exit),
        .open_gate       (open_gate),
        .close_gate      (close_gate),
        .wrong_pin       (wrong_pin),
        .blocked_gate    (blocked_gate),
        .gate_alarm      (gate_alarm),
        .lot_full        (lot_full),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enter_code(input logic [15:0] c);
        code       = c;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        code       = '0;
    endtask

    task automatic arrive();
        vehicle_arrival = 1'b1;
        tick();
        vehicle_arrival = 1'b0;
    endtask

    task automatic admit();
        arrive();
        enter_code(16'h1234);
        vehicle_left = 1'b1;
        tick();
        vehicle_left = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        vehicle_arrival = 1'b0;
        code            = '0;
        code_valid      = 1'b0;
        vehicle_left    = 1'b0;
        vehicle_exit    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_open", open_gate, 0);
        chk("rst_block", blocked_gate, 0);
        chk("rst_alarm", gate_alarm, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_full", lot_full, 0);

        // Normal admission
        arrive();
        chk("wait_open", open_gate, 0);
        enter_code(16'h1234);
        chk("ok_open", open_gate, 1);
        chk("ok_close", close_gate, 0);
        vehicle_left = 1'b1;
        tick();
        vehicle_left = 1'b0;
        chk("left_open", open_gate, 0);
        chk("left_close", close_gate, 1);
        chk("left_occ", occupancy, 1);
        tick();
        chk("close_pulse", close_gate, 0);

        // Three wrong codes lock out, correct code releases
        arrive();
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h0000);
            chk("wp_pulse", wrong_pin, 1);
            chk("wp_block", blocked_gate, (i == 2) ? 1 : 0);
            tick();
            chk("wp_low", wrong_pin, 0);
        end
        enter_code(16'h0000);
        chk("blk_nowp", wrong_pin, 0);
        chk("blk_hold", blocked_gate, 1);
        enter_code(16'h1234);
        chk("blk_clear", blocked_gate, 0);
        chk("blk_noopen", open_gate, 0);

        // Timeout: code on cycle 64 still accepted, idle for 64 cycles expires
        arrive();
        repeat (63) tick();
        enter_code(16'h0000);
        chk("to_not_yet", wrong_pin, 1);
        repeat (63) tick();
        chk("to_63_block", blocked_gate, 0);
        tick();
        enter_code(16'h0000);
        chk("to_idle_nowp", wrong_pin, 0);
        arrive();
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h0000);
            chk("to_retry_wp", wrong_pin, 1);
            chk("to_retry_blk", blocked_gate, (i == 2) ? 1 : 0);
        end
        enter_code(16'h1234);
        chk("to_unblock", blocked_gate, 0);

        // Tailgating alarm
        arrive();
        enter_code(16'h1234);
        chk("tg_open", open_gate, 1);
        vehicle_arrival = 1'b1;
        vehicle_left    = 1'b1;
        tick();
        vehicle_arrival = 1'b0;
        vehicle_left    = 1'b0;
        chk("tg_open0", open_gate, 0);
        chk("tg_alarm", gate_alarm, 1);
        chk("tg_block", blocked_gate, 1);
        chk("tg_close", close_gate, 0);
        chk("tg_occ", occupancy, 2);
        enter_code(16'h4321);
        chk("tg_wrong_alarm", gate_alarm, 1);
        chk("tg_wrong_nowp", wrong_pin, 0);
        arrive();
        chk("tg_arr_alarm", gate_alarm, 1);
        enter_code(16'h1234);
        chk("tg_clr_alarm", gate_alarm, 0);
        chk("tg_clr_block", blocked_gate, 0);

        // Fill the lot
        for (int i = 3; i <= 8; i++) begin
            admit();
            chk("fill_occ", occupancy, i);
        end
        chk("full_flag", lot_full, 1);
        vehicle_arrival = 1'b1;
        tick();
        tick();
        vehicle_arrival = 1'b0;
        enter_code(16'h1234);
        chk("full_noopen", open_gate, 0);
        chk("full_occ", occupancy, 8);
        vehicle_exit = 1'b1;
        tick();
        vehicle_exit = 1'b0;
        chk("exit_occ", occupancy, 7);
        chk("exit_full", lot_full, 0);

        // Simultaneous entry and exit cancel
        arrive();
        enter_code(16'h1234);
        vehicle_left = 1'b1;
        vehicle_exit = 1'b1;
        tick();
        vehicle_left = 1'b0;
        vehicle_exit = 1'b0;
        chk("both_occ", occupancy, 7);
        chk("both_close", close_gate, 1);

        // Drain and saturate at zero
        vehicle_exit = 1'b1;
        repeat (8) tick();
        vehicle_exit = 1'b0;
        chk("drain_occ", occupancy, 0);

        // Asynchronous reset mid-OPEN
        admit();
        chk("pre_rst_occ", occupancy, 1);
        arrive();
        enter_code(16'h1234);
        chk("pre_rst_open", open_gate, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_open", open_gate, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_block", blocked_gate, 0);
        tick();
        rst = 1'b0;
        vehicle_left = 1'b1;
        tick();
        vehicle_left = 1'b0;
        chk("post_rst_occ", occupancy, 0);
        chk("post_rst_close", close_gate, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/parking_controller_param.md
PARKING_CONTROLLER_PARAM -- requirements
Module: parking_controller_param

Interface
REQ-001 Parameter CODE_W, 16, width of the entered code.
REQ-002 Parameter PIN, 16'h1234, valid access code (CODE_W bits).
REQ-003 Parameter MAX_TRIES, 3, consecutive wrong codes before lockout (1..15).
REQ-004 Parameter TIMEOUT, 64, cycles allowed in WAIT_CODE without code_valid (>=2).
REQ-005 Parameter CAPACITY, 8, parking spaces; OCC_W = $clog2(CAPACITY+1).
REQ-006 The block shall have one clock; reset is asynchronous and active-high.
REQ-007 Port clk, input, 1, rising-edge clock.
REQ-008 Port rst, input, 1, asynchronous active-high reset.
REQ-009 Port vehicle_arrival, input, 1, vehicle present at entry sensor, level.
REQ-010 Port code, input, CODE_W, entered code, sampled only when code_valid=1.
REQ-011 Port code_valid, input, 1, one-cycle strobe qualifying code.
REQ-012 Port vehicle_left, input, 1, vehicle has passed through the gate, pulse.
REQ-013 Port vehicle_exit, input, 1, vehicle left the lot via exit lane, pulse.
REQ-014 Port open_gate, output, 1, gate open command, level.
REQ-015 Port close_gate, output, 1, gate close command, one-cycle pulse.
REQ-016 Port wrong_pin, output, 1, one-cycle pulse per rejected code.
REQ-017 Port blocked_gate, output, 1, lockout active, level.
REQ-018 Port gate_alarm, output, 1, tailgating alarm, level.
REQ-019 Port lot_full, output, 1, occupancy == CAPACITY.
REQ-020 Port occupancy, output, OCC_W, vehicles currently inside.

Function
REQ-021 FSM states shall be IDLE, WAIT_CODE, OPEN, BLOCKED, ALARM; all outputs registered (one-cycle latency from triggering input edge).
REQ-022 IDLE: vehicle_arrival=1 and lot_full=0 -> WAIT_CODE, timer cleared; arrival while lot_full=1 ignored, stays IDLE.
REQ-023 WAIT_CODE: code_valid with code==PIN -> OPEN, try counter cleared.
REQ-024 WAIT_CODE: code_valid with code!=PIN -> wrong_pin pulse, tries+1; if tries reaches MAX_TRIES -> BLOCKED, else stay.
REQ-025 WAIT_CODE: TIMEOUT cycles elapsed without code_valid -> IDLE, tries cleared, no wrong_pin pulse; timer restarts on every code_valid.
REQ-026 OPEN: open_gate=1; vehicle_left alone -> close_gate pulse, open_gate=0, occupancy+1, -> IDLE.
REQ-027 OPEN: vehicle_arrival=1 and vehicle_left=1 in the same cycle -> ALARM (tailgating); occupancy+1, open_gate=0.
REQ-028 BLOCKED: blocked_gate=1; wrong codes ignored (no wrong_pin); correct code -> IDLE, tries cleared.
REQ-029 ALARM: blocked_gate=1, gate_alarm=1; only correct code clears -> IDLE; vehicle_arrival ignored.
REQ-030 Occupancy saturates: increment at CAPACITY and decrement at 0 have no effect; simultaneous increment and vehicle_exit leaves occupancy unchanged.
REQ-031 vehicle_exit is honoured in every state, independent of the FSM.
REQ-032 lot_full is combinationally equal to (occupancy == CAPACITY) from the registered counter.

Reset
REQ-033 rst=1 shall asynchronously force state IDLE, tries 0, timer 0, occupancy 0, and all outputs 0, including mid-OPEN or mid-ALARM.
REQ-034 First state transition after deassertion occurs at the first rising clk edge with rst=0.

Structure
REQ-035 Package parking_pkg shall hold the state enum and default constants (PIN, MAX_TRIES, TIMEOUT, CAPACITY).
REQ-036 Sub-module parking_occ_counter shall implement the saturating up/down occupancy counter (inc, dec, count, full).

Verification
REQ-037 Arrival, code_valid with 16'h1234, vehicle_left -> open_gate 1 one cycle after the code, close_gate pulse, occupancy 0->1, state IDLE.
REQ-038 Arrival, three codes 16'h0000 -> three wrong_pin pulses, blocked_gate=1 after the third; then 16'h1234 -> blocked_gate=0, IDLE.
REQ-039 Arrival, no code for 64 cycles -> IDLE on cycle 64; subsequent wrong code needs 3 new failures to block.
REQ-040 In OPEN, vehicle_arrival and vehicle_left asserted together -> gate_alarm=1, blocked_gate=1 until 16'h1234 entered.
REQ-041 Eight admissions -> lot_full=1, ninth arrival ignored; vehicle_exit -> occupancy 7, lot_full=0; vehicle_exit at 0 keeps 0.
REQ-042 rst asserted between clock edges while open_gate=1 -> all outputs 0 immediately, occupancy 0.
